// File: rtl/pong_gfx_pkg.sv
// Shared constants, state encoding and helpers for the pong graphics path.
package pong_gfx_pkg;

  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 32;
  localparam int X_W      = 6;
  localparam int Y_W      = 5;
  localparam int COL_W    = 3;
  localparam int NUM_PIX  = SCREEN_W * SCREEN_H;

  localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COL_W-1:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    CLEAR  = 2'd2
  } arb_state_e;

  // Bits needed to index n items; never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side pixel bus plus the registered VGA write port of the arbiter.
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import pong_gfx_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*X_W-1:0]   req_x;
  logic [NUM_REQ*Y_W-1:0]   req_y;
  logic [NUM_REQ*COL_W-1:0] req_colour;
  logic [NUM_REQ-1:0]       req_ready;
  logic [X_W-1:0]           x;
  logic [Y_W-1:0]           y;
  logic [COL_W-1:0]         colour;
  logic                     plot;
  logic                     busy;

  // Drawing side: renderers driving beats and watching the adapter port.
  modport master (
    output req_valid, req_last, req_x, req_y, req_colour,
    input  req_ready, x, y, colour, plot, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_last, req_x, req_y, req_colour,
    output req_ready, x, y, colour, plot, busy
  );

endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping to 0.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = pong_gfx_pkg::idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  logic             w_found;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_j;

  // Walk the requesters in priority order starting at the pointer.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      w_j = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA pixel-write port among NUM_REQ renderers. Round-robin in
// IDLE, burst lock until req_last (or an owner idle timeout), one registered
// pixel per clock. Optional macro VGA_CLEAR_EN adds a full-screen black sweep
// after reset before any requester is served.
module vga_plot_arbiter
  import pong_gfx_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int LOCK_TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  vga_plot_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int TW    = idx_w(LOCK_TIMEOUT);

`ifdef VGA_CLEAR_EN
  localparam int         CLR_W     = $clog2(NUM_PIX) + 1;
  localparam arb_state_e RST_STATE = CLEAR;
`else
  localparam arb_state_e RST_STATE = IDLE;
`endif

  arb_state_e       r_state, w_nxt_state;
  logic [IDX_W-1:0] r_owner, w_nxt_owner;
  logic [IDX_W-1:0] r_rr_ptr, w_nxt_ptr;
  logic [TW-1:0]    r_tcnt, w_nxt_tcnt;
`ifdef VGA_CLEAR_EN
  logic [CLR_W-1:0] r_clr_cnt, w_nxt_clr;
  logic             w_clr_done;
`endif

  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [COL_W-1:0] r_col;
  logic             r_plot;

  logic [NUM_REQ-1:0] w_pick_gnt, w_gnt;
  logic [IDX_W-1:0]   w_pick_idx, w_idx;
  logic               w_acc, w_last;

  logic [X_W-1:0]   w_x   [NUM_REQ];
  logic [Y_W-1:0]   w_y   [NUM_REQ];
  logic [COL_W-1:0] w_col [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_x[g]   = bus.req_x[g*X_W +: X_W];
    assign w_y[g]   = bus.req_y[g*Y_W +: Y_W];
    assign w_col[g] = bus.req_colour[g*COL_W +: COL_W];
  end

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_REQ-1)) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // Grant: locked owner, else round-robin pick; nothing while in reset/clear.
  always_comb begin
    w_gnt = '0;
    w_idx = r_owner;
    case (r_state)
      LOCKED:  w_gnt[r_owner] = 1'b1;
      IDLE: begin
        w_gnt = w_pick_gnt;
        w_idx = w_pick_idx;
      end
      default: w_gnt = '0;
    endcase
    if (reset) w_gnt = '0;
  end

  assign w_acc  = |(bus.req_valid & w_gnt);
  assign w_last = bus.req_last[w_idx];

`ifdef VGA_CLEAR_EN
  // Sweep runs one count past the last pixel so busy covers its plot cycle.
  assign w_clr_done = (r_clr_cnt == CLR_W'(NUM_PIX));
`endif

  // Next-state: lock on multi-beat bursts, release on last beat or timeout.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_ptr   = r_rr_ptr;
    w_nxt_tcnt  = r_tcnt;
`ifdef VGA_CLEAR_EN
    w_nxt_clr   = r_clr_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_last) begin
            w_nxt_ptr = ptr_inc(w_idx);
          end else begin
            w_nxt_state = LOCKED;
            w_nxt_owner = w_idx;
            w_nxt_tcnt  = '0;
          end
        end
      end
      LOCKED: begin
        if (w_acc) begin
          w_nxt_tcnt = '0;
          if (w_last) begin
            w_nxt_state = IDLE;
            w_nxt_ptr   = ptr_inc(r_owner);
          end
        end else if (r_tcnt == TW'(LOCK_TIMEOUT-1)) begin
          // Owner went quiet too long; hand the port back without plotting.
          w_nxt_state = IDLE;
          w_nxt_ptr   = ptr_inc(r_owner);
          w_nxt_tcnt  = '0;
        end else begin
          w_nxt_tcnt = r_tcnt + 1'b1;
        end
      end
`ifdef VGA_CLEAR_EN
      CLEAR: begin
        if (w_clr_done) begin
          w_nxt_state = IDLE;
          w_nxt_clr   = '0;
        end else begin
          w_nxt_clr = r_clr_cnt + 1'b1;
        end
      end
`endif
      default: w_nxt_state = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RST_STATE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_tcnt    <= '0;
`ifdef VGA_CLEAR_EN
      r_clr_cnt <= '0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_owner   <= w_nxt_owner;
      r_rr_ptr  <= w_nxt_ptr;
      r_tcnt    <= w_nxt_tcnt;
`ifdef VGA_CLEAR_EN
      r_clr_cnt <= w_nxt_clr;
`endif
    end
  end

  // Registered pixel port: accepted beat (or clear pixel) shows up next clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_col  <= COL_BLACK;
      r_plot <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      if (w_acc) begin
        r_x    <= w_x[w_idx];
        r_y    <= w_y[w_idx];
        r_col  <= w_col[w_idx];
        r_plot <= 1'b1;
      end
`ifdef VGA_CLEAR_EN
      if (r_state == CLEAR && !w_clr_done) begin
        r_x    <= r_clr_cnt[X_W-1:0];
        r_y    <= r_clr_cnt[X_W +: Y_W];
        r_col  <= COL_BLACK;
        r_plot <= 1'b1;
      end
`endif
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.colour    = r_col;
  assign bus.plot      = r_plot;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed scenarios plus random bursts, all
// checked each cycle against a behavioural model of the arbitration rules.
module tb_vga_plot_arbiter;
  import pong_gfx_pkg::*;

  localparam int N = 3;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_plot_arbiter_if #(.NUM_REQ(N)) bus ();

  vga_plot_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Requester stimulus
  bit tv [N];
  bit tl [N];
  int tx [N], ty [N], tc [N];
  int rem [N], gap [N];

  // Model state
  bit  m_lock;
  int  m_owner, m_ptr, m_idle, m_clr;
  bit  m_plot;
  int  m_x, m_y, m_c;
  bit  m_acc;
  int  m_win;
  logic [N-1:0] obs_rdy;

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
    m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
`ifdef VGA_CLEAR_EN
    m_clr = 0;
`else
    m_clr = -1;
`endif
  endtask

  task automatic clear_tv();
    for (int i = 0; i < N; i++) begin tv[i] = 0; tl[i] = 0; end
  endtask

  // One clock: drive, check against model, advance model, cross the edge.
  task automatic cycle();
    int w;
    logic [N-1:0] er;
    bit acc;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = tv[i];
      bus.req_last[i]           = tl[i];
      bus.req_x[6*i +: 6]       = 6'(tx[i]);
      bus.req_y[5*i +: 5]       = 5'(ty[i]);
      bus.req_colour[3*i +: 3]  = 3'(tc[i]);
    end
    #2;
    w = -1;
    if (m_lock) w = m_owner;
    else for (int k = 0; k < N; k++)
      if (w < 0 && tv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    er = '0;
    if (!rst && m_clr < 0 && w >= 0) er[w] = 1'b1;
    obs_rdy = bus.req_ready;
    chk("ready",  obs_rdy,    er);
    chk("plot",   bus.plot,   m_plot);
    chk("x",      bus.x,      m_x);
    chk("y",      bus.y,      m_y);
    chk("colour", bus.colour, m_c);
    chk("busy",   bus.busy,   (m_lock || m_clr >= 0));
    acc = (w >= 0) && er[w] && tv[w];
    m_acc = 0; m_win = -1;
    if (rst) begin
      model_reset();
    end else if (m_clr >= 0) begin
      if (m_clr < NUM_PIX) begin
        m_plot = 1; m_x = m_clr % SCREEN_W; m_y = m_clr / SCREEN_W; m_c = 0;
        m_clr++;
      end else begin
        m_plot = 0; m_clr = -1;
      end
    end else begin
      m_plot = 0;
      if (acc) begin
        m_plot = 1; m_x = tx[w]; m_y = ty[w]; m_c = tc[w];
        m_acc = 1; m_win = w;
      end
      if (m_lock) begin
        if (acc) begin
          m_idle = 0;
          if (tl[w]) begin m_lock = 0; m_ptr = (w + 1) % N; end
        end else begin
          m_idle++;
          if (m_idle == T) begin m_lock = 0; m_ptr = (m_owner + 1) % N; m_idle = 0; end
        end
      end else if (acc) begin
        if (tl[w]) m_ptr = (w + 1) % N;
        else begin m_lock = 1; m_owner = w; m_idle = 0; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic sweep();
    int guard = 0;
    while (m_clr >= 0 && guard < NUM_PIX + 16) begin cycle(); guard++; end
    chk("sweep_end", (m_clr < 0), 1);
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0; clear_tv(); sweep();
  endtask

  task automatic agents_pre();
    for (int i = 0; i < N; i++) if (!tv[i]) begin
      if (gap[i] > 0) gap[i]--;
      else begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 5);
        if (rem[i] > 0) begin
          tv[i] = 1; tl[i] = (rem[i] == 1);
          tx[i] = $urandom_range(0, 63); ty[i] = $urandom_range(0, 31); tc[i] = $urandom_range(0, 7);
        end
      end
    end
  endtask

  task automatic agents_post();
    int r;
    if (m_acc) begin
      tv[m_win] = 0; rem[m_win]--;
      r = $urandom_range(0, 19);
      if (rem[m_win] > 0 && r >= 17) gap[m_win] = $urandom_range(13, 18);
      else if (r >= 12)              gap[m_win] = $urandom_range(1, 3);
      else                           gap[m_win] = 0;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      tv[i] = 1; tl[i] = 1; tx[i] = 0; ty[i] = 0; tc[i] = 0; rem[i] = 0; gap[i] = 0;
    end
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    // Reset state with every requester valid: ready must stay low.
    cycle();
    chk("rst_plot", bus.plot, 0);
    chk("rst_x", bus.x, 0);
    rst = 0; clear_tv(); sweep();

    // Single pixel from req0.
    tv[0] = 1; tl[0] = 1; tx[0] = 10; ty[0] = 5; tc[0] = 7;
    cycle();
    chk("sp_rdy", obs_rdy, 3'b001);
    tv[0] = 0;
    chk("sp_plot", bus.plot, 1);
    chk("sp_x", bus.x, 10);
    chk("sp_y", bus.y, 5);
    chk("sp_col", bus.colour, 7);
    // Pointer now at 1: req1 beats req0.
    tv[0] = 1; tv[1] = 1; tl[0] = 1; tl[1] = 1;
    cycle();
    chk("sp_ptr", obs_rdy, 3'b010);
    clear_tv();

    // 8-beat burst from req0 with req1 waiting throughout.
    n = 0;
    tv[1] = 1; tl[1] = 1; tx[1] = 33; ty[1] = 17; tc[1] = 2;
    for (int k = 0; k < 8; k++) begin
      tv[0] = 1; tl[0] = (k == 7); tx[0] = 20 + k; ty[0] = k; tc[0] = k;
      cycle();
      if (obs_rdy == 3'b001) n++;
    end
    tv[0] = 0;
    chk("burst_cnt", n, 8);
    chk("burst_lastx", bus.x, 27);
    cycle();
    chk("burst_next", obs_rdy, 3'b010);
    clear_tv();
    cycle();
    chk("burst_r1x", bus.x, 33);

    // Fairness from a fresh reset.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        tv[i] = 1; tl[i] = 1; tx[i] = $urandom_range(0, 63); ty[i] = $urandom_range(0, 31); tc[i] = i;
      end
      cycle();
      chk("rr_order", obs_rdy, 3'b001 << (k % 3));
    end
    clear_tv();

    // Timeout: req2 locks and goes silent.
    tv[2] = 1; tl[2] = 0; tx[2] = 1; ty[2] = 2; tc[2] = 3;
    cycle();
    chk("to_lock", obs_rdy, 3'b100);
    tv[2] = 0; tv[0] = 1; tv[1] = 1; tl[0] = 1; tl[1] = 1;
    n = 0;
    for (int k = 0; k < T; k++) begin
      cycle();
      n += int'(bus.plot);
    end
    chk("to_noplot", n, 0);
    chk("to_busy", bus.busy, 0);
    cycle();
    chk("to_next", obs_rdy, 3'b001);
    clear_tv();

    // Reset in the middle of a 4-beat req1 burst.
    for (int k = 0; k < 2; k++) begin
      tv[1] = 1; tl[1] = 0; tx[1] = 40 + k; tv[0] = 1; tl[0] = 1;
      cycle();
    end
    rst = 1;
    cycle();
    chk("mr_rdy", obs_rdy, 0);
    chk("mr_plot", bus.plot, 0);
    rst = 0; clear_tv(); sweep();
    for (int i = 0; i < N; i++) begin tv[i] = 1; tl[i] = 1; end
    cycle();
    chk("mr_ptr", obs_rdy, 3'b001);
    clear_tv();
    cycle();

    // Random traffic.
    for (int i = 0; i < N; i++) begin rem[i] = 0; gap[i] = 0; end
    repeat (3000) begin
      agents_pre();
      cycle();
      agents_post();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
